counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Command-driven controller that sequences a 4-bit up/down count register. It accepts LOAD, COUNT_UP, COUNT_DOWN and CLEAR commands over a valid/ready handshake and runs multi-step counts with hold and abort. It reports completion and wrap-around events. It sits between a host/control FSM and the counting datapath, and replaces free-running separate up and down counters with one sequenced resource.

Parameters:
WIDTH, 4, count register width
STEP_W, 8, width of the step-count field (max run length 2^STEP_W-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
cmd_data  in  WIDTH  load value (LOAD only)
cmd_steps  in  STEP_W  number of steps (UP/DOWN only)
hold  in  1  freeze an active run
abort  in  1  terminate an active run
count  out  WIDTH  current count value
dir  out  1  direction of last/current run: 0 up, 1 down
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
wrap  out  1  one-cycle pulse on modular wrap

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, dir=0, busy=0, done=0, wrap=0, cmd_ready=1, remaining=0. Reset mid-run discards the run with no done pulse.
- All outputs are registered. cmd_ready=1 exactly in IDLE. Accept = cmd_valid & cmd_ready at a rising edge.
- States: IDLE and RUN.
- IDLE, LOAD accepted: at the accept edge, count<=cmd_data and done<=1. State stays IDLE.
- IDLE, CLEAR accepted: at the accept edge, count<=0 and dir<=0. done<=1.
- IDLE, UP/DOWN accepted with cmd_steps=0: done<=1 and count is unchanged. dir is still updated.
- IDLE, UP/DOWN accepted with cmd_steps=N>0: remaining<=N, dir<=op, busy<=1, cmd_ready<=0, state<=RUN. Count does not move at the accept edge.
- RUN, each edge with hold=0 and abort=0:
  - count<=count±1 mod 2^WIDTH.
  - remaining<=remaining-1.
  - wrap<=1 on the 15->0 transition (up) or the 0->15 transition (down) for WIDTH=4.
- RUN, step where remaining=1: in the same edge as the final step, state<=IDLE, busy<=0, cmd_ready<=1, done<=1. With no hold, latency is N edges after accept, and done coincides with the final count value.
- RUN, hold=1: count, remaining and state freeze. wrap and done stay 0.
- RUN, abort=1 (priority over hold): state<=IDLE, busy<=0, cmd_ready<=1. count is retained, no step is taken, done stays 0.
- done and wrap are high for exactly one cycle. Both may be high in the same cycle when the final step wraps.
- cmd_valid during RUN is ignored (no accept). The host must hold the command until cmd_ready.
- A new command may be accepted in the cycle done is high.
- hold and abort are ignored in IDLE.

Decomposition:
- Shared package counter_seq_pkg holds:
  - op enum (OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR)
  - state enum (ST_IDLE, ST_RUN)
  - WIDTH and STEP_W defaults
- One sub-module, updown_count_core. Inputs: clk, reset, en, dir, load, load_val. Outputs: count and a wrap pulse. It holds the modular arithmetic.
- counter_sequencer holds the FSM, the remaining counter, the handshake and done generation.

Test Plan:
- Reset: hold reset=0 then release -> count=0, busy=0, cmd_ready=1, done=0, wrap=0. Assert reset mid-RUN -> all return to reset values immediately, with no done pulse.
- LOAD: cmd_data=4'hA -> count=10 after the accept edge, done one cycle, cmd_ready stays 1.
- UP across wrap: from count=14, UP with steps=3 -> count 15, 0, 1 on the next three edges. wrap pulses with count=0. done pulses with count=1. busy is high for 3 cycles.
- DOWN with hold: from count=2, DOWN with steps=4, hold=1 for 2 cycles after the first step -> count 1, 1, 1, 0, 15, 14. wrap pulses at 15. done pulses at 14, 6 cycles after accept.
- Zero steps and busy rejection: UP with steps=0 -> done next cycle, count unchanged. During a RUN, cmd_valid with LOAD is not accepted and count is unaffected.
- Abort: UP with steps=10 from count=0, abort after 3 steps -> count=3, IDLE, done never asserted. A following CLEAR yields count=0 and done.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sequencer and its count core.
package counter_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned STEP_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_UP    = 2'b01,
        OP_DOWN  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/updown_count_core.sv
// Modular up/down count register with synchronous load and a one-cycle wrap pulse.
module updown_count_core
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic at_edge;

    // Wrap happens when stepping past the top (up) or below zero (down).
    assign at_edge = dir ? (count == '0) : (count == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_val;
            end else if (en) begin
                count <= dir ? (count - CNT_ONE) : (count + CNT_ONE);
                wrap  <= at_edge;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a shared up/down count register: load, clear and
// multi-step runs with hold/abort, plus registered done and wrap pulses.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    state_e             state, state_nxt;
    op_e                op;
    logic               accept;
    logic               is_run_op;
    logic               last_step;
    logic [STEP_W-1:0]  remaining, remaining_nxt;
    logic               dir_nxt;
    logic               done_nxt;
    logic               core_en;
    logic               core_load;
    logic [WIDTH-1:0]   core_load_val;

    assign op        = op_e'(cmd_op);
    assign accept    = cmd_valid & cmd_ready;
    assign is_run_op = (op == OP_UP) || (op == OP_DOWN);
    assign last_step = (remaining == STEP_W'(1));

    // State flops double as the ready/busy outputs.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_run_op && (cmd_steps != '0)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (!hold && last_step)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Abort outranks hold; a held run takes no step and raises no pulse.
    always_comb begin
        remaining_nxt = remaining;
        dir_nxt       = dir;
        done_nxt      = 1'b0;
        core_en       = 1'b0;
        core_load     = 1'b0;
        core_load_val = cmd_data;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD: begin
                            core_load = 1'b1;
                            done_nxt  = 1'b1;
                        end
                        OP_CLEAR: begin
                            core_load     = 1'b1;
                            core_load_val = '0;
                            dir_nxt       = 1'b0;
                            done_nxt      = 1'b1;
                        end
                        default: begin
                            dir_nxt = (op == OP_DOWN);
                            if (cmd_steps == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                remaining_nxt = cmd_steps;
                            end
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    remaining_nxt = '0;
                end else if (!hold) begin
                    core_en       = 1'b1;
                    remaining_nxt = remaining - STEP_W'(1);
                    done_nxt      = last_step;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            dir       <= 1'b0;
            done      <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            dir       <= dir_nxt;
            done      <= done_nxt;
        end
    end

    updown_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (core_en),
        .dir      (dir),
        .load     (core_load),
        .load_val (core_load_val),
        .count    (count),
        .wrap     (wrap)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: a behavioural model pushes the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_counter_sequencer;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned STEP_W = 8;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             dir;
        logic             busy;
        logic             ready;
        logic             done;
        logic             wrap;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              hold;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              busy;
    logic              done;
    logic              wrap;

    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    int   last_done_cyc = -1;
    int   done_cnt = 0;
    int   wrap_cnt = 0;
    exp_t exp_q[$];

    // Reference model state
    logic             m_run;
    logic [WIDTH-1:0] m_count;
    logic             m_dir;
    logic [STEP_W-1:0] m_rem;

    counter_sequencer #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .hold      (hold),
        .abort     (abort),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_count = '0;
        m_dir   = 1'b0;
        m_rem   = '0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus (called at a falling edge), predict, then compare.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] d,
                       input logic [STEP_W-1:0] st, input logic h, input logic a);
        exp_t e;
        exp_t g;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cmd_steps = st;
        hold      = h;
        abort     = a;
        e.done = 1'b0;
        e.wrap = 1'b0;
        if (!m_run) begin
            if (v) begin
                if (op == 2'b00) begin
                    m_count = d;
                    e.done  = 1'b1;
                end else if (op == 2'b11) begin
                    m_count = '0;
                    m_dir   = 1'b0;
                    e.done  = 1'b1;
                end else begin
                    m_dir = (op == 2'b10);
                    if (st == '0) e.done = 1'b1;
                    else begin
                        m_rem = st;
                        m_run = 1'b1;
                    end
                end
            end
        end else if (a) begin
            m_run = 1'b0;
        end else if (!h) begin
            if (m_dir) begin
                if (m_count == 4'd0) e.wrap = 1'b1;
                m_count = m_count - 4'd1;
            end else begin
                if (m_count == 4'd15) e.wrap = 1'b1;
                m_count = m_count + 4'd1;
            end
            m_rem = m_rem - 8'd1;
            if (m_rem == 8'd0) begin
                m_run  = 1'b0;
                e.done = 1'b1;
            end
        end
        e.count = m_count;
        e.dir   = m_dir;
        e.busy  = m_run;
        e.ready = !m_run;
        exp_q.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (done) begin
            last_done_cyc = cyc_n;
            done_cnt++;
        end
        if (wrap) wrap_cnt++;
        g = exp_q.pop_front();
        check_eq("count", 32'(count), 32'(g.count));
        check_eq("dir", 32'(dir), 32'(g.dir));
        check_eq("busy", 32'(busy), 32'(g.busy));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(g.ready));
        check_eq("done", 32'(done), 32'(g.done));
        check_eq("wrap", 32'(wrap), 32'(g.wrap));
    endtask

    task automatic idle_cyc(input logic h, input logic a);
        cyc(1'b0, 2'b00, '0, '0, h, a);
    endtask

    int acc_cyc;
    int w0;

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_steps = '0;
        hold      = 1'b0;
        abort     = 1'b0;
        model_reset();

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ready", 32'(cmd_ready), 1);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_wrap", 32'(wrap), 0);
        check_eq("rst_dir", 32'(dir), 0);
        reset = 1'b1;
        idle_cyc(1'b0, 1'b0);

        // LOAD 0xA
        cyc(1'b1, 2'b00, 4'hA, 8'd0, 1'b0, 1'b0);
        check_eq("load_val", 32'(count), 10);
        check_eq("load_done", 32'(done), 1);
        idle_cyc(1'b0, 1'b0);
        check_eq("load_done_1cyc", 32'(done), 0);

        // UP across wrap from 14, 3 steps
        cyc(1'b1, 2'b00, 4'd14, 8'd0, 1'b0, 1'b0);
        w0 = wrap_cnt;
        cyc(1'b1, 2'b01, 4'd0, 8'd3, 1'b0, 1'b0);
        acc_cyc = cyc_n;
        idle_cyc(1'b0, 1'b0);
        check_eq("up_c15", 32'(count), 15);
        idle_cyc(1'b0, 1'b0);
        check_eq("up_c0_wrap", 32'({count, wrap}), 32'({4'd0, 1'b1}));
        idle_cyc(1'b0, 1'b0);
        check_eq("up_c1_done", 32'({count, done, busy}), 32'({4'd1, 1'b1, 1'b0}));
        check_eq("up_latency", 32'(last_done_cyc - acc_cyc), 3);
        check_eq("up_wrap_cnt", 32'(wrap_cnt - w0), 1);

        // DOWN from 2, 4 steps, hold 2 cycles after first step
        cyc(1'b1, 2'b00, 4'd2, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 4'd0, 8'd4, 1'b0, 1'b0);
        acc_cyc = cyc_n;
        idle_cyc(1'b0, 1'b0);
        idle_cyc(1'b1, 1'b0);
        idle_cyc(1'b1, 1'b0);
        check_eq("dn_hold_c1", 32'(count), 1);
        idle_cyc(1'b0, 1'b0);
        idle_cyc(1'b0, 1'b0);
        check_eq("dn_c15_wrap", 32'({count, wrap}), 32'({4'd15, 1'b1}));
        idle_cyc(1'b0, 1'b0);
        check_eq("dn_c14_done", 32'({count, done}), 32'({4'd14, 1'b1}));
        check_eq("dn_latency", 32'(last_done_cyc - acc_cyc), 6);

        // Zero steps
        cyc(1'b1, 2'b01, 4'd0, 8'd0, 1'b0, 1'b0);
        check_eq("zero_done", 32'({count, done, busy, dir}), 32'({4'd14, 1'b1, 1'b0, 1'b0}));

        // LOAD offered during a run is ignored
        cyc(1'b1, 2'b01, 4'd0, 8'd2, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 4'd5, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 4'd5, 8'd0, 1'b0, 1'b0);
        check_eq("busy_rej_count", 32'(count), 0);
        idle_cyc(1'b0, 1'b0);

        // Abort after 3 steps from 0, then CLEAR
        cyc(1'b1, 2'b11, 4'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'b01, 4'd0, 8'd10, 1'b0, 1'b0);
        done_cnt = 0;
        repeat (3) idle_cyc(1'b0, 1'b0);
        idle_cyc(1'b1, 1'b1);
        idle_cyc(1'b0, 1'b0);
        check_eq("abort_state", 32'({count, busy, cmd_ready}), 32'({4'd3, 1'b0, 1'b1}));
        check_eq("abort_no_done", 32'(done_cnt), 0);
        cyc(1'b1, 2'b11, 4'd0, 8'd0, 1'b0, 1'b0);
        check_eq("clear_after_abort", 32'({count, done}), 32'({4'd0, 1'b1}));

        // Reset in the middle of a run
        cyc(1'b1, 2'b00, 4'd7, 8'd0, 1'b0, 1'b0);
        cyc(1'b1, 2'b10, 4'd0, 8'd5, 1'b0, 1'b0);
        idle_cyc(1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_count", 32'(count), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 1);
        check_eq("mid_rst_dir", 32'(dir), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        repeat (6) idle_cyc(1'b0, 1'b0);
        check_eq("mid_rst_no_done", 32'(done_cnt), 0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                8'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0));
        end

        check_eq("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
